// File: rtl/line_buffer_3row.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer_3row
// Brief    : Two line memories turning a raster pixel stream into vertically
//            aligned 3-row column triples for 3x3 window filters.
// Revision : 1.0 - initial release
// ============================================================================
module line_buffer_3row #(
    parameter int WIDTH      = 24,
    parameter int PIC_WIDTH  = 480,
    parameter int PIC_HEIGHT = 272
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic                         sof,
    input  logic [WIDTH-1:0]             din,
    output logic                         valid_out,
    output logic [WIDTH-1:0]             dout1,
    output logic [WIDTH-1:0]             dout2,
    output logic [WIDTH-1:0]             dout3,
    output logic [$clog2(PIC_WIDTH)-1:0] col_out
);

    localparam int c_CW = $clog2(PIC_WIDTH);
    localparam int c_RW = (PIC_HEIGHT > 1) ? $clog2(PIC_HEIGHT) : 1;

    logic [c_CW-1:0]  r_col;
    logic [c_RW-1:0]  r_row;
    logic [c_CW-1:0]  w_col;
    logic [c_RW-1:0]  w_row;
    logic [c_CW-1:0]  w_col_nxt;
    logic [c_RW-1:0]  w_row_nxt;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_primed;

    logic [WIDTH-1:0] r_lb1 [PIC_WIDTH];
    logic [WIDTH-1:0] r_lb2 [PIC_WIDTH];

    logic             r_valid_out;
    logic [WIDTH-1:0] r_dout1;
    logic [WIDTH-1:0] r_dout2;
    logic [WIDTH-1:0] r_dout3;
    logic [c_CW-1:0]  r_col_out;

    // sof forces the current pixel to (col 0, row 0) whatever the counters say
    always_comb begin
        w_col      = sof ? '0 : r_col;
        w_row      = sof ? '0 : r_row;
        w_col_last = (w_col == c_CW'(PIC_WIDTH - 1));
        w_row_last = (w_row == c_RW'(PIC_HEIGHT - 1));
        w_col_nxt  = w_col_last ? '0 : w_col + c_CW'(1);
        w_row_nxt  = w_row;
        if (w_col_last) begin
            w_row_nxt = w_row_last ? '0 : w_row + c_RW'(1);
        end
        w_primed   = ({1'b0, w_row} >= (c_RW + 1)'(2));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col       <= '0;
            r_row       <= '0;
            r_valid_out <= 1'b0;
            r_dout1     <= '0;
            r_dout2     <= '0;
            r_dout3     <= '0;
            r_col_out   <= '0;
        end else begin
            r_valid_out <= valid_in & w_primed;
            if (valid_in) begin
                r_col     <= w_col_nxt;
                r_row     <= w_row_nxt;
                r_dout3   <= din;
                r_dout2   <= r_lb1[w_col];
                r_dout1   <= r_lb2[w_col];
                r_col_out <= w_col;
            end
        end
    end

    // Memories are never emitted before being rewritten, so they carry no reset
    always_ff @(posedge clk) begin
        if (valid_in) begin
            r_lb1[w_col] <= din;
            r_lb2[w_col] <= r_lb1[w_col];
        end
    end

    assign valid_out = r_valid_out;
    assign dout1     = r_dout1;
    assign dout2     = r_dout2;
    assign dout3     = r_dout3;
    assign col_out   = r_col_out;

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_3row.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_buffer_3row
// Brief    : Self-checking bench: frame-image model plus directed literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_buffer_3row;

    localparam int PW = 4;
    localparam int PH = 4;
    localparam int WD = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid_in = 1'b0;
    logic          sof = 1'b0;
    logic [WD-1:0] din = '0;
    logic          valid_out;
    logic [WD-1:0] dout1, dout2, dout3;
    logic [1:0]    col_out;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_pulse = 0;
    logic chk_en = 1'b0;

    line_buffer_3row #(.WIDTH(WD), .PIC_WIDTH(PW), .PIC_HEIGHT(PH)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .sof(sof), .din(din),
        .valid_out(valid_out), .dout1(dout1), .dout2(dout2), .dout3(dout3),
        .col_out(col_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: pixels land in an image array indexed by a linear raster position
    logic [WD-1:0] img [0:PH-1][0:PW-1];
    int            m_idx;
    int            t_idx, t_r, t_c;
    logic          e_valid, e_k1, e_k2;
    logic [WD-1:0] e_d1, e_d2, e_d3;
    int            e_col;

    assign t_idx = sof ? 0 : m_idx;
    assign t_r   = t_idx / PW;
    assign t_c   = t_idx % PW;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idx   <= 0;
            e_valid <= 1'b0;
            e_d1    <= '0;
            e_d2    <= '0;
            e_d3    <= '0;
            e_col   <= 0;
            e_k1    <= 1'b1;
            e_k2    <= 1'b1;
        end else begin
            e_valid <= 1'b0;
            if (valid_in) begin
                e_valid <= (t_r >= 2);
                e_d3    <= din;
                e_col   <= t_c;
                e_k2    <= (t_r >= 1);
                e_k1    <= (t_r >= 2);
                if (t_r >= 1) e_d2 <= img[t_r-1][t_c];
                if (t_r >= 2) e_d1 <= img[t_r-2][t_c];
                img[t_r][t_c] <= din;
                m_idx   <= (t_idx + 1) % (PW * PH);
            end
        end
    end

    always @(negedge clk) begin
        if (valid_out === 1'b1) n_pulse <= n_pulse + 1;
        if (chk_en) begin
            chk("m_valid", {31'b0, valid_out}, {31'b0, e_valid});
            chk("m_dout3", {8'b0, dout3}, {8'b0, e_d3});
            chk("m_col",   {30'b0, col_out}, e_col);
            if (e_k2) chk("m_dout2", {8'b0, dout2}, {8'b0, e_d2});
            if (e_k1) chk("m_dout1", {8'b0, dout1}, {8'b0, e_d1});
        end
    end

    task automatic px(input logic s, input logic [WD-1:0] d);
        @(negedge clk);
        valid_in = 1'b1;
        sof      = s;
        din      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
            sof      = 1'b0;
        end
    endtask

    task automatic chk_out(input string nm, input logic v, input logic [WD-1:0] d3,
                           input logic [WD-1:0] d2, input logic [WD-1:0] d1, input logic [1:0] c);
        chk({nm, "_valid"}, {31'b0, valid_out}, {31'b0, v});
        chk({nm, "_dout3"}, {8'b0, dout3}, {8'b0, d3});
        chk({nm, "_dout2"}, {8'b0, dout2}, {8'b0, d2});
        chk({nm, "_dout1"}, {8'b0, dout1}, {8'b0, d1});
        chk({nm, "_col"},   {30'b0, col_out}, {30'b0, c});
    endtask

    int n0;

    initial begin
        #1 rst = 1'b1;
        #2 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk_out("reset", 1'b0, 24'h0, 24'h0, 24'h0, 2'd0);
        rst = 1'b0;

        // Priming rows 0-1, then first emitted triple
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < PW; c++) begin
                px(1'b0, WD'(r * 16 + c));
                chk("prime_valid", {31'b0, valid_out}, 32'd0);
            end
        px(1'b0, 24'h20);
        chk_out("first", 1'b1, 24'h20, 24'h10, 24'h00, 2'd0);

        // Gap of three idle cycles inside a line
        px(1'b0, 24'h21);
        idle(3);
        @(posedge clk);
        #1;
        chk_out("gap_hold", 1'b0, 24'h21, 24'h11, 24'h01, 2'd1);
        px(1'b0, 24'h22);
        chk_out("resume", 1'b1, 24'h22, 24'h12, 24'h02, 2'd2);
        px(1'b0, 24'h23);
        for (int c = 0; c < PW; c++) px(1'b0, WD'(48 + c));
        idle(2);

        // Two continuous frames
        n0 = n_pulse;
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < PH; r++)
                for (int c = 0; c < PW; c++) begin
                    px(1'b0, WD'(r * 16 + c));
                    if (r == 1 && c == 3) begin
                        chk("eol_col", {30'b0, col_out}, 32'd3);
                        chk("eol_valid", {31'b0, valid_out}, 32'd0);
                    end
                    if (r == 2 && c == 0) begin
                        chk("bol_col", {30'b0, col_out}, 32'd0);
                        chk("bol_valid", {31'b0, valid_out}, 32'd1);
                        if (f == 1) chk_out("frame2", 1'b1, 24'h20, 24'h10, 24'h00, 2'd0);
                    end
                end
        idle(2);
        chk("pulse_count", n_pulse - n0, 32'd16);

        // sof mid-frame at row 3 col 1
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < PW; c++) px(1'b0, WD'(r * 16 + c));
        px(1'b0, 24'h30);
        px(1'b1, 24'hA0);
        chk("sof_valid", {31'b0, valid_out}, 32'd0);
        for (int k = 1; k < 8; k++) begin
            px(1'b0, WD'(24'hA0 + k));
            chk("post_sof_valid", {31'b0, valid_out}, 32'd0);
        end
        px(1'b0, 24'hB0);
        chk_out("sof_emit", 1'b1, 24'hB0, 24'hA4, 24'hA0, 2'd0);
        px(1'b0, 24'hB1);

        // Asynchronous reset during activity
        #2 rst = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 24'h0, 24'h0, 24'h0, 2'd0);
        idle(2);
        rst = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < PW; c++) px(1'b0, WD'(r * 16 + c));
        px(1'b0, 24'h20);
        chk_out("after_rst", 1'b1, 24'h20, 24'h10, 24'h00, 2'd0);
        idle(3);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/line_buffer_3row.md
LINE_BUFFER_3ROW -- requirements
Module: line_buffer_3row

Interface
REQ-001 SHALL have parameter WIDTH, default 24, giving pixel width as packed {R[23:16],G[15:8],B[7:0]}.
REQ-002 SHALL have parameter PIC_WIDTH, default 480, giving pixels per line.
REQ-003 SHALL have parameter PIC_HEIGHT, default 272, giving lines per frame.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, reset; asynchronous assertion and active-high.
REQ-006 SHALL have port valid_in, input, 1 bit, qualifying din this cycle.
REQ-007 SHALL have port sof, input, 1 bit, start of frame; sampled only when valid_in=1.
REQ-008 SHALL have port din, input, WIDTH bits, raster-order pixel stream.
REQ-009 SHALL have port valid_out, output, 1 bit, qualifying dout1..dout3.
REQ-010 SHALL have port dout1, output, WIDTH bits, pixel from line N-2, same column.
REQ-011 SHALL have port dout2, output, WIDTH bits, pixel from line N-1, same column.
REQ-012 SHALL have port dout3, output, WIDTH bits, current-line pixel (line N).
REQ-013 SHALL have port col_out, output, clog2(PIC_WIDTH) bits, column index of the emitted triple.

Function
REQ-014 SHALL contain two line memories, LB1 and LB2, each PIC_WIDTH x WIDTH, addressed by column counter col.
REQ-015 SHALL keep col (0..PIC_WIDTH-1) and row (0..PIC_HEIGHT-1); both advance only on valid_in=1.
REQ-016 On valid_in=1, col SHALL increment; at PIC_WIDTH-1 col SHALL wrap to 0 and row SHALL increment; at row PIC_HEIGHT-1 with col wrap, row SHALL wrap to 0.
REQ-017 On valid_in=1 with sof=1, din SHALL be treated as col 0, row 0 regardless of counter state; counters then continue from col 1, row 0.
REQ-018 On valid_in=1, at address c = current col: dout3<=din, dout2<=LB1[c], dout1<=LB2[c], LB1[c]<=din, LB2[c]<=LB1[c], col_out<=c (read-before-write).
REQ-019 Latency SHALL be exactly 1 cycle from valid_in to corresponding valid_out.
REQ-020 valid_out SHALL be registered: 1 the cycle after valid_in=1 with effective row >= 2, else 0.
REQ-021 During effective rows 0 and 1, memories SHALL still be written; valid_out SHALL stay 0 (priming).
REQ-022 When valid_in=0: counters, memories, dout1..dout3 and col_out SHALL hold; valid_out SHALL be 0 next cycle.
REQ-023 Gaps in valid_in (within or between lines) SHALL NOT disturb column alignment.
REQ-024 Frame wrap (row returns to 0) SHALL re-prime: valid_out 0 for the first two lines of each frame; stale memory contents never emitted.
REQ-025 Throughput SHALL be one pixel per cycle with no backpressure.

Reset
REQ-026 While rst=1: col=0, row=0, valid_out=0, dout1=dout2=dout3=0, col_out=0, effective immediately (asynchronous).
REQ-027 Line memory contents SHALL NOT require reset; REQ-024 priming guarantees they are never emitted before rewrite.
REQ-028 Reset mid-frame SHALL abandon the frame; the next valid pixel after release is col 0, row 0.

Verification (PIC_WIDTH=4, PIC_HEIGHT=4, din = row*16+col unless noted)
REQ-029 Assert rst during activity -> same cycle valid_out=0, dout1..3=0, col_out=0; after release first pixel taken as col 0, row 0.
REQ-030 Stream rows 0-1 (8 pixels) -> valid_out=0 throughout; pixel 0x20 (row 2 col 0) -> next cycle valid_out=1, dout3=0x20, dout2=0x10, dout1=0x00, col_out=0.
REQ-031 Drop valid_in for 3 cycles after 0x21 -> outputs hold 0x21/0x11/0x01, valid_out=0; resume with 0x22 -> dout2=0x12, dout1=0x02, col_out=2.
REQ-032 Continuous 2 frames (32 pixels) -> exactly 16 valid_out pulses; frame 2 rows 0-1 produce none; frame 2 row 2 col 0 emits 0x20/0x10/0x00.
REQ-033 Assert sof with pixel at row 3 col 1 -> counters restart; next 7 valid pixels produce valid_out=0, the 9th pixel emits valid_out=1 with col_out=0.
REQ-034 Back-to-back valid_in across line boundary (0x13 then 0x20) -> col_out sequence 3,0 with no bubble and row increments once.
